// File: rtl/systola_pkg.sv
// Shared definitions for the systolic-array front end: default geometry and sizing helpers.
package systola_pkg;

  localparam int unsigned WORDLEN_DEFAULT = 8;
  localparam int unsigned ROWS_DEFAULT    = 16;
  localparam int unsigned COLS_DEFAULT    = 16;
  localparam int unsigned DEPTH_DEFAULT   = 8;

  // Ceiling log2, never less than 1 so a single-row select still has a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w = w + 1;
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Single-channel synchronous FIFO with registered read data, one per array row.
module row_fifo
  import systola_pkg::*;
#(
  parameter int unsigned WORDLEN = WORDLEN_DEFAULT,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [WORDLEN-1:0] din,
  output logic [WORDLEN-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORDLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q, count_d;
  logic [WORDLEN-1:0] dout_q;
  logic               push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = dout_q;

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since the count guards reads.
  always_ff @(posedge clk) begin
    if (push_ok && !rst && !clr) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        dout_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/skewed_row_feeder.sv
// Bank of per-row FIFOs drained in lockstep, with a diagonal skew so row r lags row 0 by r cycles.
module skewed_row_feeder
  import systola_pkg::*;
#(
  parameter int unsigned ROWS    = ROWS_DEFAULT,
  parameter int unsigned WORDLEN = WORDLEN_DEFAULT,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  localparam int unsigned RW     = clog2_min1(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [RW-1:0]           wr_row,
  input  logic [WORDLEN-1:0]      wr_data,
  input  logic                    fire,
  output logic [ROWS*WORDLEN-1:0] row_data,
  output logic [ROWS-1:0]         row_valid,
  output logic [ROWS-1:0]         full,
  output logic [ROWS-1:0]         empty,
  output logic                    busy,
  output logic                    err_ovf,
  output logic                    err_udf
);

  localparam logic [RW:0] RowsW = (RW+1)'(ROWS);

  logic [ROWS-1:0]    fifo_full, fifo_empty, push;
  logic [WORDLEN-1:0] fifo_dout [ROWS];
  logic               row_ok, pop, ovf_evt, udf_evt;
  logic               pop_q;  // FIFO dout registers hold freshly popped words
  logic [ROWS-1:0]    vld_q, vld_d;
  logic               busy_q, err_ovf_q, err_udf_q;

  // Write decode and error detection; fullness is judged before any same-cycle pop.
  always_comb begin
    row_ok  = ({1'b0, wr_row} < RowsW);
    pop     = fire && (fifo_empty == '0);
    udf_evt = fire && (fifo_empty != '0);
    ovf_evt = wr_en && (!row_ok || fifo_full[wr_row]);
    for (int r = 0; r < ROWS; r++) begin
      push[r] = wr_en && row_ok && (wr_row == RW'(r)) && !fifo_full[r];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    row_fifo #(
      .WORDLEN (WORDLEN),
      .DEPTH   (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (push[r]),
      .pop   (pop),
      .din   (wr_data),
      .dout  (fifo_dout[r]),
      .full  (fifo_full[r]),
      .empty (fifo_empty[r])
    );

    logic [WORDLEN-1:0] chain_q [0:r];

    // Skew chain for this row: stage 0 plus r delay stages, zero when no word is in flight.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        for (int k = 0; k <= r; k++) chain_q[k] <= '0;
      end else begin
        chain_q[0] <= pop_q ? fifo_dout[r] : '0;
        for (int k = 1; k <= r; k++) chain_q[k] <= chain_q[k-1];
      end
    end

    assign row_data[r*WORDLEN +: WORDLEN] = chain_q[r];
  end

  // Valid bit of skew stage k is shared by every row that still has stage k.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = pop_q;
    for (int k = 1; k < ROWS; k++) vld_d[k] = vld_q[k-1];
  end

  // Pipeline valids, busy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pop_q     <= 1'b0;
      vld_q     <= '0;
      busy_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      pop_q     <= pop;
      vld_q     <= vld_d;
      busy_q    <= |vld_d;
      err_ovf_q <= err_ovf_q | ovf_evt;
      err_udf_q <= err_udf_q | udf_evt;
    end
  end

  assign row_valid = vld_q;
  assign full      = fifo_full;
  assign empty     = fifo_empty;
  assign busy      = busy_q;
  assign err_ovf   = err_ovf_q;
  assign err_udf   = err_udf_q;

endmodule

// File: tb/tb_skewed_row_feeder.sv
// Directed bench for skewed_row_feeder with ROWS=4, DEPTH=4, WORDLEN=8.
module tb_skewed_row_feeder;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned WORDLEN = 8;
  localparam int unsigned DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, fire;
  logic [1:0]  wr_row;
  logic [7:0]  wr_data;
  logic [31:0] row_data;
  logic [3:0]  row_valid, full, empty;
  logic        busy, err_ovf, err_udf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  skewed_row_feeder #(
    .ROWS    (ROWS),
    .WORDLEN (WORDLEN),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .fire      (fire),
    .row_data  (row_data),
    .row_valid (row_valid),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf)
  );

  typedef struct packed {
    logic        we;
    logic [1:0]  row;
    logic [7:0]  d;
    logic        f;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [3:0]  ee;
    logic [3:0]  ef;
    logic        eb;
    logic        eo;
    logic        eu;
  } vec_t;

  vec_t vecs [15];

  logic [4:0] hist;
  int         cnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] row, input logic [7:0] d,
                       input logic f);
    wr_en   = we;
    wr_row  = row;
    wr_data = d;
    fire    = f;
  endtask

  // One cycle of the streaming test; popm says whether the bench popped at this edge.
  task automatic step5(input logic popm);
    logic [31:0] ed;
    logic [3:0]  ev;
    tick;
    hist = {hist[3:0], popm};
    ed   = '0;
    for (int r = 0; r < 4; r++) begin
      ev[r] = hist[r+1];
      if (ev[r]) begin
        ed[r*8 +: 8] = 8'(8'h40 + r*16 + cnt[r]);
        cnt[r]++;
      end
    end
    chk("stream_valid", {28'h0, row_valid}, {28'h0, ev});
    chk("stream_data", row_data, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] anyv;
    int         n2;
    int         base;
    int         rounds [3];

    vecs[0]  = '{1'b1, 2'd0, 8'h10, 1'b0, 4'h0, 32'h0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 8'h11, 1'b0, 4'h0, 32'h0, 4'b1100, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 8'h12, 1'b0, 4'h0, 32'h0, 4'b1000, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 2'd3, 8'h13, 1'b0, 4'h0, 32'h0, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 4'h0, 32'h0, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b0001, 32'h0000_0010, 4'b1111, 4'h0, 1'b1, 1'b0,
                 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b0010, 32'h0000_1100, 4'b1111, 4'h0, 1'b1, 1'b0,
                 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b0100, 32'h0012_0000, 4'b1111, 4'h0, 1'b1, 1'b0,
                 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1000, 32'h1300_0000, 4'b1111, 4'h0, 1'b1, 1'b0,
                 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'h0, 32'h0, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 8'hA0, 1'b0, 4'h0, 32'h0, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'd2, 8'hA1, 1'b0, 4'h0, 32'h0, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'd2, 8'hA2, 1'b0, 4'h0, 32'h0, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 2'd2, 8'hA3, 1'b0, 4'h0, 32'h0, 4'b1011, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 2'd2, 8'hFF, 1'b0, 4'h0, 32'h0, 4'b1011, 4'b0100, 1'b0, 1'b1, 1'b0};

    // Reset
    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    chk("rst_empty", {28'h0, empty}, 32'hF);
    chk("rst_full", {28'h0, full}, 32'h0);
    chk("rst_valid", {28'h0, row_valid}, 32'h0);
    chk("rst_data", row_data, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_errs", {30'h0, err_ovf, err_udf}, 32'h0);

    // Skewed drain and overflow fill, vector table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].we, vecs[i].row, vecs[i].d, vecs[i].f);
      tick;
      chk($sformatf("v%0d_valid", i), {28'h0, row_valid}, {28'h0, vecs[i].ev});
      chk($sformatf("v%0d_data", i), row_data, vecs[i].ed);
      chk($sformatf("v%0d_empty", i), {28'h0, empty}, {28'h0, vecs[i].ee});
      chk($sformatf("v%0d_full", i), {28'h0, full}, {28'h0, vecs[i].ef});
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].eb});
      chk($sformatf("v%0d_errs", i), {30'h0, err_ovf, err_udf},
          {30'h0, vecs[i].eo, vecs[i].eu});
    end

    // Overflow: drain row 2 and make sure FF never appears
    for (int r = 0; r < 4; r++) begin
      if (r == 2) continue;
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 2'(r), 8'(8'h30 + i), 1'b0);
        tick;
      end
    end
    n2 = 0;
    for (int t = 0; t < 8; t++) begin
      drive(1'b0, 2'd0, 8'h00, t < 4);
      tick;
      if (row_valid[2]) begin
        chk("ovf_pop_row2", {24'h0, row_data[23:16]}, 32'(8'hA0 + n2));
        n2++;
      end
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("ovf_pop_count", n2, 4);
    chk("ovf_after_empty", {28'h0, empty}, 32'hF);
    chk("ovf_sticky", {31'h0, err_ovf}, 32'h1);

    // Underflow with row 1 empty
    drive(1'b1, 2'd0, 8'h01, 1'b0);
    tick;
    drive(1'b1, 2'd2, 8'h02, 1'b0);
    tick;
    drive(1'b1, 2'd3, 8'h03, 1'b0);
    tick;
    chk("udf_pre_empty", {28'h0, empty}, 32'b0010);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    tick;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("udf_flag", {31'h0, err_udf}, 32'h1);
    chk("udf_empty", {28'h0, empty}, 32'b0010);
    anyv = row_valid;
    for (int t = 0; t < 5; t++) begin
      tick;
      anyv = anyv | row_valid;
    end
    chk("udf_no_valid", {28'h0, anyv}, 32'h0);

    // Clear between tests
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("clr_empty", {28'h0, empty}, 32'hF);
    chk("clr_full", {28'h0, full}, 32'h0);
    chk("clr_errs", {30'h0, err_ovf, err_udf}, 32'h0);

    // Wrap and throughput: 10 words per row in bursts of 4, 4, 2
    hist = '0;
    for (int r = 0; r < 4; r++) cnt[r] = 0;
    rounds[0] = 4;
    rounds[1] = 4;
    rounds[2] = 2;
    base = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < rounds[k]; i++) begin
        for (int r = 0; r < 4; r++) begin
          drive(1'b1, 2'(r), 8'(8'h40 + r*16 + base + i), 1'b0);
          step5(1'b0);
        end
      end
      for (int i = 0; i < rounds[k]; i++) begin
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        step5(1'b1);
      end
      drive(1'b0, 2'd0, 8'h00, 1'b0);
      base += rounds[k];
    end
    for (int t = 0; t < 6; t++) step5(1'b0);
    for (int r = 0; r < 4; r++) chk($sformatf("stream_count_r%0d", r), cnt[r], 10);
    chk("stream_empty", {28'h0, empty}, 32'hF);
    chk("stream_busy", {31'h0, busy}, 32'h0);
    chk("stream_errs", {30'h0, err_ovf, err_udf}, 32'h0);

    // clr mid-stream, with an error flag already raised
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    tick;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("mid_udf_set", {31'h0, err_udf}, 32'h1);
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 2'(r), 8'(8'h70 + r), 1'b0);
      tick;
    end
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    tick;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick;
    chk("mid_row0_valid", {28'h0, row_valid}, 32'b0001);
    chk("mid_row0_data", row_data, 32'h70);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("mid_clr_valid", {28'h0, row_valid}, 32'h0);
    chk("mid_clr_busy", {31'h0, busy}, 32'h0);
    chk("mid_clr_empty", {28'h0, empty}, 32'hF);
    chk("mid_clr_errs", {30'h0, err_ovf, err_udf}, 32'h0);
    chk("mid_clr_data", row_data, 32'h0);
    anyv = '0;
    for (int t = 0; t < 4; t++) begin
      tick;
      anyv = anyv | row_valid;
    end
    chk("mid_clr_quiet", {28'h0, anyv}, 32'h0);
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 2'(r), 8'(8'h80 + r), 1'b0);
      tick;
    end
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    tick;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    tick;
    chk("refill_row0_valid", {28'h0, row_valid}, 32'b0001);
    chk("refill_row0_data", row_data, 32'h80);
    tick;
    chk("refill_row1_valid", {28'h0, row_valid}, 32'b0010);
    chk("refill_row1_data", row_data, 32'h8100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
